// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer width helper, pointer type and Gray helpers for the async FIFO.
package fifo_pkg;
  localparam logic [1:0] FULL_MSB_INV = 2'b11;
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction
  localparam int ADDR_W_DEF = 4;
  localparam int PTR_W_DEF = ptr_w(ADDR_W_DEF);
  typedef logic [PTR_W_DEF-1:0] ptr_t;
  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction
endpackage

// File: rtl/bin2gray.sv
// bin2gray: combinational binary-to-Gray encoder.
module bin2gray #(
  parameter int W = 5
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);
  assign gray = bin ^ (bin >> 1);
endmodule

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary decoder.
module gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end
endmodule

// File: rtl/fifo_wptr_ctrl.sv
// fifo_wptr_ctrl: async FIFO write-side pointers and registered full/almost-full/level/overflow status.
// FIFO_OVF_STICKY_EN: adds ovf_clr and makes overflow sticky until cleared.
module fifo_wptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int AF_MARGIN = 2,
  localparam int PTR_W = ptr_w(ADDR_W)
) (
  input  logic              wclk,
  input  logic              wrst,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  rptr_gray_sync,
`ifdef FIFO_OVF_STICKY_EN
  input  logic              ovf_clr,
`endif
  output logic              wr_accept,
  output logic [ADDR_W-1:0] waddr,
  output logic [PTR_W-1:0]  wptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [PTR_W-1:0]  wr_level,
  output logic              overflow
);
  localparam logic [PTR_W-1:0] AF_TH = PTR_W'(2**ADDR_W - AF_MARGIN);
  logic [PTR_W-1:0] wbin, wbin_next, wgray_next, rbin_sync, level_next;
  logic full_next;
  assign wr_accept = wr_en && !full;
  assign wbin_next = wbin + PTR_W'(wr_accept);
  assign waddr = wbin[ADDR_W-1:0];
  assign level_next = wbin_next - rbin_sync;
  // Full when write Gray equals read Gray with its two MSBs inverted (one lap ahead).
  assign full_next = wgray_next == {rptr_gray_sync[PTR_W-1:PTR_W-2] ^ FULL_MSB_INV, rptr_gray_sync[PTR_W-3:0]};
  bin2gray #(.W(PTR_W)) u_b2g (.bin(wbin_next), .gray(wgray_next));
  gray2bin #(.W(PTR_W)) u_g2b (.gray(rptr_gray_sync), .bin(rbin_sync));
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin <= '0;
      wptr_gray <= '0;
      full <= 1'b0;
      almost_full <= 1'b0;
      wr_level <= '0;
      overflow <= 1'b0;
    end else begin
      wbin <= wbin_next;
      wptr_gray <= wgray_next;
      full <= full_next;
      almost_full <= level_next >= AF_TH;
      wr_level <= level_next;
`ifdef FIFO_OVF_STICKY_EN
      overflow <= (wr_en && full) || (overflow && !ovf_clr);
`else
      overflow <= wr_en && full;
`endif
    end
  end
endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// tb_fifo_wptr_ctrl: randomized self-checking bench for fifo_wptr_ctrl against an occupancy-count model.
module tb_fifo_wptr_ctrl;
  localparam int DEPTH = 16, AF_MARGIN = 2, MASK = 31;
  logic wclk = 0, wrst = 1, wr_en = 0;
  logic [4:0] rptr_gray_sync = '0;
`ifdef FIFO_OVF_STICKY_EN
  logic ovf_clr = 0;
`endif
  logic wr_accept, full, almost_full, overflow;
  logic [3:0] waddr;
  logic [4:0] wptr_gray, wr_level;
  int checks = 0, errors = 0;
  int m_w = 0, m_r = 0;
  bit m_full = 0, m_ovf = 0, exp_acc, act_acc;
  always #5 wclk = ~wclk;
  fifo_wptr_ctrl #(.ADDR_W(4), .AF_MARGIN(AF_MARGIN)) dut (
    .wclk(wclk), .wrst(wrst), .wr_en(wr_en), .rptr_gray_sync(rptr_gray_sync),
`ifdef FIFO_OVF_STICKY_EN
    .ovf_clr(ovf_clr),
`endif
    .wr_accept(wr_accept), .waddr(waddr), .wptr_gray(wptr_gray), .full(full),
    .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
  );
  function automatic logic [4:0] gray(input int b);
    int v = b & MASK;
    return 5'(v ^ (v >> 1));
  endfunction
  function automatic int lvl();
    return (m_w - m_r) & MASK;
  endfunction
  task automatic drive(input bit we, input int rb);
    bit old_full;
    wr_en = we;
    rptr_gray_sync = gray(rb);
    #2 act_acc = wr_accept;
    exp_acc = we && !m_full;
    old_full = m_full;
    @(posedge wclk);
    if (exp_acc) m_w = (m_w + 1) & MASK;
    m_r = rb & MASK;
    m_full = lvl() == DEPTH;
`ifdef FIFO_OVF_STICKY_EN
    m_ovf = (we && old_full) || (m_ovf && !ovf_clr);
`else
    m_ovf = we && old_full;
`endif
    #1;
  endtask
  task automatic do_reset;
    wrst = 1;
    wr_en = 0;
    rptr_gray_sync = '0;
    @(posedge wclk);
    #1 wrst = 0;
    m_w = 0; m_r = 0; m_full = 0; m_ovf = 0;
  endtask
  task automatic test_reset;
    repeat (2) @(posedge wclk);
    #1;
    checks++; if ({wptr_gray, wr_level, full, almost_full, overflow, waddr} !== 17'h0) begin errors++; $display("FAIL reset_init: got %h expected 0", {wptr_gray, wr_level, full, almost_full, overflow, waddr}); end
    wrst = 0;
    repeat (5) drive(1, 0);
    checks++; if (wptr_gray !== 5'b00111) begin errors++; $display("FAIL reset_pre_gray: got %b expected 00111", wptr_gray); end
    #1 wrst = 1;
    #1;
    checks++; if ({wptr_gray, wr_level, full, almost_full, overflow, waddr} !== 17'h0) begin errors++; $display("FAIL reset_async: got %h expected 0", {wptr_gray, wr_level, full, almost_full, overflow, waddr}); end
    @(posedge wclk);
    #1 wrst = 0;
    m_w = 0; m_r = 0; m_full = 0; m_ovf = 0;
    #1;
    checks++; if (waddr !== 4'd0) begin errors++; $display("FAIL reset_waddr: got %0d expected 0", waddr); end
    drive(1, 0);
    checks++; if (act_acc !== 1'b1) begin errors++; $display("FAIL reset_first_acc: got %b expected 1", act_acc); end
    checks++; if (wptr_gray !== 5'b00001) begin errors++; $display("FAIL reset_first_gray: got %b expected 00001", wptr_gray); end
  endtask
  task automatic test_fill;
    do_reset();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1, 0);
      checks++; if (wr_level !== 5'(i)) begin errors++; $display("FAIL fill_level%0d: got %0d expected %0d", i, wr_level, i); end
      checks++; if (almost_full !== (i >= DEPTH - AF_MARGIN)) begin errors++; $display("FAIL fill_af%0d: got %b expected %b", i, almost_full, i >= DEPTH - AF_MARGIN); end
      checks++; if (full !== (i == DEPTH)) begin errors++; $display("FAIL fill_full%0d: got %b expected %b", i, full, i == DEPTH); end
    end
    drive(1, 0);
    checks++; if (act_acc !== 1'b0) begin errors++; $display("FAIL ovf_acc: got %b expected 0", act_acc); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", overflow); end
    checks++; if (wptr_gray !== 5'b11000) begin errors++; $display("FAIL ovf_gray: got %b expected 11000", wptr_gray); end
    drive(0, 0);
    checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL ovf_after: got %b expected %b", overflow, m_ovf); end
  endtask
  task automatic test_drain;
    drive(0, 1);
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL drain_full: got %b expected 0", full); end
    checks++; if (wr_level !== 5'd15) begin errors++; $display("FAIL drain_level: got %0d expected 15", wr_level); end
    checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL drain_af: got %b expected 1", almost_full); end
  endtask
  task automatic test_simultaneous;
    drive(1, 2);
    checks++; if (act_acc !== 1'b1) begin errors++; $display("FAIL simul_acc: got %b expected 1", act_acc); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL simul_full: got %b expected 0", full); end
    checks++; if (wr_level !== 5'd15) begin errors++; $display("FAIL simul_level: got %0d expected 15", wr_level); end
  endtask
  task automatic test_wrap;
    int writes = 0, cyc = 0;
    bit saw_wrap = 0;
    logic [4:0] prev;
    while (writes < 40 && cyc < 200) begin
      int old_w = m_w;
      prev = wptr_gray;
      drive(1, m_r + $urandom_range(0, lvl()));
      cyc++;
      if (exp_acc) writes++;
      checks++; if (wptr_gray !== gray(m_w)) begin errors++; $display("FAIL wrap_gray: got %b expected %b", wptr_gray, gray(m_w)); end
      checks++; if (wr_level !== 5'(lvl())) begin errors++; $display("FAIL wrap_level: got %0d expected %0d", wr_level, lvl()); end
      checks++; if (full !== m_full) begin errors++; $display("FAIL wrap_full: got %b expected %b", full, m_full); end
      checks++; if ($countones(prev ^ wptr_gray) !== int'(exp_acc)) begin errors++; $display("FAIL wrap_onebit: got %b -> %b expected %0d bit change", prev, wptr_gray, exp_acc); end
      if (exp_acc && old_w == 31) begin
        saw_wrap = 1;
        checks++; if ({prev, wptr_gray} !== 10'b10000_00000) begin errors++; $display("FAIL wrap_31_0: got %b -> %b expected 10000 -> 00000", prev, wptr_gray); end
      end
    end
    checks++; if (!saw_wrap || writes != 40) begin errors++; $display("FAIL wrap_budget: got writes=%0d wrap=%b expected 40 and 1", writes, saw_wrap); end
  endtask
  task automatic test_random;
    for (int c = 0; c < 150; c++) begin
      drive($urandom_range(0, 3) != 0, m_r + (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, lvl())));
      checks++; if (act_acc !== exp_acc) begin errors++; $display("FAIL rand_acc: got %b expected %b", act_acc, exp_acc); end
      checks++; if (wptr_gray !== gray(m_w)) begin errors++; $display("FAIL rand_gray: got %b expected %b", wptr_gray, gray(m_w)); end
      checks++; if (waddr !== 4'(m_w)) begin errors++; $display("FAIL rand_waddr: got %0d expected %0d", waddr, m_w & 15); end
      checks++; if (wr_level !== 5'(lvl())) begin errors++; $display("FAIL rand_level: got %0d expected %0d", wr_level, lvl()); end
      checks++; if (full !== m_full) begin errors++; $display("FAIL rand_full: got %b expected %b", full, m_full); end
      checks++; if (almost_full !== (lvl() >= DEPTH - AF_MARGIN)) begin errors++; $display("FAIL rand_af: got %b expected %b", almost_full, lvl() >= DEPTH - AF_MARGIN); end
      checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf: got %b expected %b", overflow, m_ovf); end
    end
  endtask
`ifdef FIFO_OVF_STICKY_EN
  task automatic test_sticky;
    do_reset();
    repeat (DEPTH + 1) drive(1, 0);
    repeat (3) drive(0, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sticky_hold: got %b expected 1", overflow); end
    ovf_clr = 1;
    drive(0, 0);
    ovf_clr = 0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sticky_clr: got %b expected 0", overflow); end
    ovf_clr = 1;
    drive(1, 0);
    ovf_clr = 0;
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sticky_set_prio: got %b expected 1", overflow); end
  endtask
`endif
  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_simultaneous();
    test_wrap();
    test_random();
`ifdef FIFO_OVF_STICKY_EN
    test_sticky();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
